// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: display FSM states, BCD time word, mux selects.
// Imported by the lap record controller and its record buffer.
package stopwatch_pkg;

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_VIEW = 1'b1
  } state_e;

  // 8 packed BCD digits, digit 0 in [3:0]
  typedef logic [31:0] bcd_time_t;

  localparam logic DISP_LIVE = 1'b0;
  localparam logic DISP_REC  = 1'b1;

endpackage

// File: rtl/lap_record_buf.sv
// DEPTH x 32 lap store: one sync write port, one registered read port.
// Ports: clk, reset_n, we_i/waddr_i/wdata_i, re_i/raddr_i, clr_i, rdata_o.
module lap_record_buf
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  bcd_time_t        wdata_i,
  input  logic             re_i,
  input  logic [PTR_W-1:0] raddr_i,
  input  logic             clr_i,
  output bcd_time_t        rdata_o
);

  bcd_time_t mem_q [DEPTH];
  bcd_time_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Bypass so a lap written this edge is visible at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      if (we_i && (waddr_i == raddr_i))
        rdata_q <= wdata_i;
      else
        rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lap_record_ctrl.sv
// Lap capture ring plus LIVE/VIEW browse FSM with inactivity timeout.
// Ports: clk, reset_n, live_time, button pulses, tick -> disp_sel, rec_data, view_idx, rec_count, full.
module lap_record_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int TIMEOUT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      live_time,
  input  logic             lap_save,
  input  logic             view_toggle,
  input  logic             next,
  input  logic             clear,
  input  logic             tick,
  output logic             disp_sel,
  output logic [31:0]      rec_data,
  output logic [PTR_W-1:0] view_idx,
  output logic [PTR_W:0]   rec_count,
  output logic             full
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             we;
  logic             clr;
  logic             re;
  logic [PTR_W-1:0] rd_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_LIVE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
    end
  end

  // Only the highest-priority event acts each cycle
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    we       = 1'b0;
    clr      = 1'b0;
    if (clear) begin
      clr      = 1'b1;
      state_d  = ST_LIVE;
      wr_ptr_d = '0;
      cnt_d    = '0;
      idx_d    = '0;
      tmo_d    = '0;
    end else if (lap_save) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      idx_d    = '0;
      tmo_d    = '0;
    end else if (view_toggle) begin
      if (state_q == ST_VIEW) begin
        state_d = ST_LIVE;
        idx_d   = '0;
      end else if (cnt_q != '0) begin
        state_d = ST_VIEW;
        idx_d   = '0;
        tmo_d   = '0;
      end
    end else if (next) begin
      if (state_q == ST_VIEW) begin
        if ({1'b0, idx_q} == cnt_q - 1'b1)
          idx_d = '0;
        else
          idx_d = idx_q + 1'b1;
        tmo_d = '0;
      end
    end else if (tick) begin
      if (state_q == ST_VIEW) begin
        if (tmo_q == TMO_LAST) begin
          state_d = ST_LIVE;
          idx_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end
  end

  // Next-state addressing keeps rec_data aligned with view_idx
  assign rd_addr = wr_ptr_d - 1'b1 - idx_d;
  assign re      = (state_d == ST_VIEW);

  lap_record_buf #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (live_time),
    .re_i    (re),
    .raddr_i (rd_addr),
    .clr_i   (clr),
    .rdata_o (rec_data)
  );

  assign disp_sel  = (state_q == ST_VIEW) ? DISP_REC : DISP_LIVE;
  assign view_idx  = idx_q;
  assign rec_count = cnt_q;
  assign full      = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_lap_record_ctrl.sv
// Randomised and directed bench for lap_record_ctrl against a queue model.
// Newest record sits at the front of the model queue.
module tb_lap_record_ctrl;

  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;
  localparam int TIMEOUT = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      live_time;
  logic             lap_save, view_toggle, next, clear, tick;
  logic             disp_sel;
  logic [31:0]      rec_data;
  logic [PTR_W-1:0] view_idx;
  logic [PTR_W:0]   rec_count;
  logic             full;

  always #5 clk = ~clk;

  lap_record_ctrl #(
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .live_time   (live_time),
    .lap_save    (lap_save),
    .view_toggle (view_toggle),
    .next        (next),
    .clear       (clear),
    .tick        (tick),
    .disp_sel    (disp_sel),
    .rec_data    (rec_data),
    .view_idx    (view_idx),
    .rec_count   (rec_count),
    .full        (full)
  );

  int vectors = 0;
  int errors  = 0;

  // Behavioural model
  logic [31:0] recs[$];
  bit          m_view;
  int          m_idx;
  int          m_tmo;
  logic [31:0] m_rd;

  function automatic void model_reset();
    recs.delete();
    m_view = 0;
    m_idx  = 0;
    m_tmo  = 0;
    m_rd   = '0;
  endfunction

  function automatic void model_step(input bit ls, vt, nx, cl, tk,
                                     input logic [31:0] lt);
    if (cl) begin
      model_reset();
    end else if (ls) begin
      recs.push_front(lt);
      if (recs.size() > DEPTH) void'(recs.pop_back());
      m_idx = 0;
      m_tmo = 0;
      if (m_view) m_rd = recs[0];
    end else if (vt) begin
      if (m_view) begin
        m_view = 0;
        m_idx  = 0;
      end else if (recs.size() > 0) begin
        m_view = 1;
        m_idx  = 0;
        m_tmo  = 0;
        m_rd   = recs[0];
      end
    end else if (nx) begin
      if (m_view) begin
        m_idx = (m_idx + 1) % recs.size();
        m_tmo = 0;
        m_rd  = recs[m_idx];
      end
    end else if (tk) begin
      if (m_view) begin
        m_tmo++;
        if (m_tmo == TIMEOUT) begin
          m_view = 0;
          m_idx  = 0;
          m_tmo  = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("disp_sel", 32'(disp_sel), 32'(m_view));
    chk("rec_data", rec_data, m_rd);
    chk("view_idx", 32'(view_idx), 32'(m_idx));
    chk("rec_count", 32'(rec_count), 32'(recs.size()));
    chk("full", 32'(full), 32'(recs.size() == DEPTH));
  endtask

  task automatic step(input bit ls, vt, nx, cl, tk,
                      input logic [31:0] lt);
    lap_save    = ls;
    view_toggle = vt;
    next        = nx;
    clear       = cl;
    tick        = tk;
    live_time   = lt;
    @(posedge clk);
    #1;
    model_step(ls, vt, nx, cl, tk, lt);
    lap_save    = 0;
    view_toggle = 0;
    next        = 0;
    clear       = 0;
    tick        = 0;
    vectors++;
    compare();
  endtask

  task automatic save(input logic [31:0] v);
    step(1, 0, 0, 0, 0, v);
  endtask

  task automatic idle(input bit vt, nx, cl, tk);
    step(0, vt, nx, cl, tk, $urandom);
  endtask

  initial begin
    reset_n = 1;
    live_time = '0;
    lap_save = 0; view_toggle = 0; next = 0; clear = 0; tick = 0;
    model_reset();
    #2 reset_n = 0;
    #1;
    chk("rst_disp_sel", 32'(disp_sel), 32'd0);
    chk("rst_rec_data", rec_data, 32'd0);
    chk("rst_count", 32'(rec_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    compare();

    // Toggle with nothing stored is ignored
    idle(1, 0, 0, 0);
    chk("empty_toggle", 32'(disp_sel), 32'd0);

    save(32'h123);
    save(32'h456);
    save(32'h789);
    idle(1, 0, 0, 0);
    chk("view_first", rec_data, 32'h789);
    chk("view_sel", 32'(disp_sel), 32'd1);
    idle(0, 1, 0, 0);
    chk("next1", rec_data, 32'h456);
    idle(0, 1, 0, 0);
    chk("next2", rec_data, 32'h123);
    idle(0, 1, 0, 0);
    chk("next_wrap", rec_data, 32'h789);
    chk("next_wrap_idx", 32'(view_idx), 32'd0);
    idle(1, 0, 0, 0);

    // Overflow the ring
    idle(0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) save(32'(i));
    chk("ovf_count", 32'(rec_count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    idle(1, 0, 0, 0);
    chk("ovf_newest", rec_data, 32'd10);
    for (int i = 0; i < 7; i++) idle(0, 1, 0, 0);
    chk("ovf_oldest", rec_data, 32'd3);

    // Timeout after five idle ticks
    for (int i = 0; i < 4; i++) idle(0, 0, 0, 1);
    chk("tmo_4", 32'(disp_sel), 32'd1);
    idle(0, 0, 0, 1);
    chk("tmo_5", 32'(disp_sel), 32'd0);

    // Next restarts the timeout count
    idle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle(0, 0, 0, 1);
    idle(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) idle(0, 0, 0, 1);
    chk("tmo_restart", 32'(disp_sel), 32'd1);
    idle(0, 0, 0, 1);
    chk("tmo_restart_end", 32'(disp_sel), 32'd0);

    // Clear beats lap_save while viewing
    idle(1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 32'h99);
    chk("clr_count", 32'(rec_count), 32'd0);
    chk("clr_sel", 32'(disp_sel), 32'd0);
    chk("clr_data", rec_data, 32'd0);

    // Asynchronous reset while viewing index 2
    save(32'h11);
    save(32'h22);
    save(32'h33);
    idle(1, 0, 0, 0);
    idle(0, 1, 0, 0);
    idle(0, 1, 0, 0);
    chk("pre_rst_idx", 32'(view_idx), 32'd2);
    reset_n = 0;
    #1;
    chk("arst_sel", 32'(disp_sel), 32'd0);
    chk("arst_idx", 32'(view_idx), 32'd0);
    chk("arst_data", rec_data, 32'd0);
    chk("arst_count", 32'(rec_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1;
    compare();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
           $urandom_range(0, 2) == 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lap_record_ctrl.md
Name: lap_record_ctrl

Overview:
Controller that sequences the stopwatch display path between the live time and stored lap records. It captures lap times into a circular record buffer and runs a LIVE/VIEW browsing state machine with an inactivity timeout. It drives the 32-bit display mux select and the stored-record operand, and its outputs feed the 32-bit mux ahead of sseg_control. All time values are 8-digit packed BCD, 4 bits per digit, with digit 0 in bits [3:0].

Parameters:
DEPTH, 8, number of lap records held; must be a power of two.
PTR_W, 3, log2(DEPTH).
TIMEOUT, 5, number of tick pulses without a button event before VIEW returns to LIVE; minimum 1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
live_time  in  32  current stopwatch time (BCD)
lap_save  in  1  one-cycle pulse: store live_time as a new record
view_toggle  in  1  one-cycle pulse: enter or leave VIEW
next  in  1  one-cycle pulse: step to the next-older record while in VIEW
clear  in  1  one-cycle pulse: erase all records
tick  in  1  one-cycle timebase pulse (e.g. 1 Hz) for the timeout
disp_sel  out  1  mux select: 0 = live_time, 1 = rec_data
rec_data  out  32  selected stored record
view_idx  out  PTR_W  age index of the displayed record; 0 = newest
rec_count  out  PTR_W+1  number of valid records, 0..DEPTH
full  out  1  high when rec_count == DEPTH

Behaviour:
- Reset (async assert, sync release):
  - state LIVE; disp_sel 0; rec_data 0; view_idx 0; rec_count 0; full 0.
  - wr_ptr 0; timeout counter 0.
  - Buffer contents are don't-care.
- Buffer:
  - On lap_save, write live_time at wr_ptr, then wr_ptr++ modulo DEPTH.
  - rec_count increments and saturates at DEPTH.
  - When full, a save overwrites the oldest record.
  - Record at age k lives at (wr_ptr - 1 - k) mod DEPTH.
- Event priority per cycle: clear > lap_save > view_toggle > next > tick. Only the highest-priority asserted event takes effect; lower ones in the same cycle are dropped.
- State LIVE:
  - disp_sel 0.
  - view_toggle with rec_count > 0: go to VIEW, view_idx 0, timeout counter 0.
  - view_toggle with rec_count == 0: ignored.
  - next and tick: ignored.
- State VIEW:
  - disp_sel 1.
  - view_toggle: go to LIVE.
  - next: view_idx = view_idx + 1, wrapping to 0 when view_idx == rec_count - 1. Timeout counter cleared.
  - lap_save: record stored; stay in VIEW; view_idx forced to 0 so the new lap is shown; timeout counter cleared.
  - tick: timeout counter++. When the counter would reach TIMEOUT, go to LIVE and clear the counter.
- clear, in any state:
  - rec_count 0, wr_ptr 0, view_idx 0, full 0.
  - Go to LIVE; rec_data 0 on the next cycle.
- Latency:
  - rec_data is registered and reflects the record at view_idx one cycle after view_idx or the buffer changes.
  - disp_sel changes on the same edge as the state.
  - In the first VIEW cycle rec_data is already valid, because the read address is computed from next-state values.
- Outputs:
  - rec_data holds its last value in LIVE.
  - view_idx is 0 whenever the state is LIVE.
- Reset mid-VIEW: immediate return to reset values, asynchronously.
- Widths:
  - All pointer arithmetic is modulo 2^PTR_W.
  - rec_count is PTR_W+1 bits so that DEPTH is representable.

Decomposition:
- Shared package stopwatch_pkg holds:
  - the state enum (ST_LIVE, ST_VIEW);
  - a BCD time type (32-bit, 8 digits);
  - the DISP_LIVE / DISP_REC select constants.
- One sub-module, lap_record_buf: DEPTH x 32 register file with one synchronous write port and one registered read port (addressed by absolute pointer), reset-free storage.
- The FSM, pointer logic and timeout counter stay in lap_record_ctrl.

Test Plan:
- Reset, then view_toggle with no records -> stays LIVE; disp_sel 0; rec_count 0.
- Save laps 0x00000123, 0x00000456, 0x00000789, then view_toggle:
  - disp_sel 1, view_idx 0, rec_data 0x00000789.
  - next -> 0x00000456; next -> 0x00000123; next -> wraps to view_idx 0, 0x00000789.
- Save 10 laps with values 1..10 (DEPTH 8) -> rec_count 8, full 1. VIEW then 7 nexts -> oldest shown is 3; newest is 10.
- In VIEW, deliver 5 ticks with no button -> returns to LIVE after the 5th tick, disp_sel 0. In a separate run, a next after tick 4 restarts the count.
- clear and lap_save in the same cycle while in VIEW -> clear wins: rec_count 0, state LIVE, no record stored.
- Assert reset_n low mid-VIEW with view_idx 2 -> outputs drop to reset values without waiting for a clock edge.
